// File: rtl/aes_sched_pkg.sv
// rtl/aes_sched_pkg.sv - shared widths, defaults and tag type for the AES job scheduler
package aes_sched_pkg;

    localparam int AES_BLK_W       = 128;
    localparam int REQ_ID_W        = 1;
    localparam int DEF_AES_LATENCY = 21;

    typedef struct packed {
        logic                valid;
        logic [REQ_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/aes_sched_fifo.sv
// rtl/aes_sched_fifo.sv - synchronous result FIFO with occupancy count
module aes_sched_fifo #(
    parameter int DEPTH = 32,
    parameter int W     = 129
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [W-1:0]           wr_data,
    input  logic                   rd_en,
    output logic [W-1:0]           rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_fire;
    logic             rd_fire;

    assign empty   = (count == '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign wr_fire = wr_en & ~full;
    assign rd_fire = rd_en & ~empty;
    // Empty head reads as zero so the response bus is clean out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wr_ptr] <= wr_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(wr_en && full));

endmodule

// File: rtl/aes_job_sched.sv
// rtl/aes_job_sched.sv - round-robin sharing of one fixed-latency AES core between two requesters
// Optional per-requester pop counters: AES_JOB_SCHED_STATS_EN.
module aes_job_sched
    import aes_sched_pkg::*;
#(
    parameter int AES_LATENCY = DEF_AES_LATENCY,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [AES_BLK_W-1:0] req0_state,
    input  logic [AES_BLK_W-1:0] req0_key,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [AES_BLK_W-1:0] req1_state,
    input  logic [AES_BLK_W-1:0] req1_key,
    output logic [AES_BLK_W-1:0] core_state,
    output logic [AES_BLK_W-1:0] core_key,
    input  logic [AES_BLK_W-1:0] core_out,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [AES_BLK_W-1:0] resp_data,
    output logic [REQ_ID_W-1:0]  resp_id,
    output logic                 busy
`ifdef AES_JOB_SCHED_STATS_EN
    ,
    output logic [31:0]          job_cnt0,
    output logic [31:0]          job_cnt1
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    logic                          last_grant;
    logic                          grant0;
    logic                          grant1;
    logic                          can_issue;
    logic                          issue;
    logic [REQ_ID_W-1:0]           issue_id;
    logic [CNT_W-1:0]              inflight;
    logic [CNT_W-1:0]              fifo_count;
    logic                          fifo_empty;
    logic                          fifo_full;
    logic                          capture;
    logic [REQ_ID_W+AES_BLK_W-1:0] fifo_rd_data;
    // Stage 0 travels with core_state; the last stage lines up with core_out.
    tag_t                          tag_sr [AES_LATENCY+1];

    assign can_issue = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_C;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = ~last_grant;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = grant0 & can_issue & ~rst;
    assign req1_ready = grant1 & can_issue & ~rst;
    assign issue      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign issue_id   = REQ_ID_W'(grant1);
    assign capture    = tag_sr[AES_LATENCY].valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            core_state <= '0;
            core_key   <= '0;
            inflight   <= '0;
            tag_sr     <= '{default: '0};
        end else begin
            if (issue) last_grant <= grant1;
            core_state <= issue ? (grant1 ? req1_state : req0_state) : '0;
            core_key   <= issue ? (grant1 ? req1_key : req0_key) : '0;
            tag_sr[0]  <= '{valid: issue, id: issue_id};
            for (int i = 1; i <= AES_LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
            case ({issue, capture})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    aes_sched_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (REQ_ID_W + AES_BLK_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (capture),
        .wr_data ({tag_sr[AES_LATENCY].id, core_out}),
        .rd_en   (resp_ready),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign resp_valid           = ~fifo_empty;
    assign {resp_id, resp_data} = fifo_rd_data;
    assign busy                 = (inflight != '0) | ~fifo_empty;

`ifdef AES_JOB_SCHED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_cnt0 <= '0;
            job_cnt1 <= '0;
        end else if (resp_valid && resp_ready) begin
            if (resp_id == '0) job_cnt0 <= job_cnt0 + 32'd1;
            else               job_cnt1 <= job_cnt1 + 32'd1;
        end
    end
`endif

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_aes_job_sched.sv
// tb/tb_aes_job_sched.sv - scoreboard bench for aes_job_sched with a stand-in pipelined core
module tb_aes_job_sched;

    localparam int LAT = 21;
    localparam logic [127:0] ZERO_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    typedef struct {
        logic         id;
        logic [127:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0, req1_valid = 1'b0;
    logic         req0_ready, req1_ready;
    logic [127:0] req0_state = '0, req0_key = '0, req1_state = '0, req1_key = '0;
    logic [127:0] core_state, core_key, core_out;
    logic         resp_valid, resp_ready = 1'b0;
    logic [127:0] resp_data;
    logic         resp_id;
    logic         busy;
`ifdef AES_JOB_SCHED_STATS_EN
    logic [31:0]  job_cnt0, job_cnt1;
`endif

    aes_job_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_state (req0_state),
        .req0_key   (req0_key),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_state (req1_state),
        .req1_key   (req1_key),
        .core_state (core_state),
        .core_key   (core_key),
        .core_out   (core_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .busy       (busy)
`ifdef AES_JOB_SCHED_STATS_EN
        ,
        .job_cnt0   (job_cnt0),
        .job_cnt1   (job_cnt1)
`endif
    );

    always #5 clk = ~clk;

    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   hs_cnt  = 0;
    int   pop_cnt [2];
    exp_t exp_q [$];
    logic grant_log [$];

    // Real AES answer for the all-zero vector, an asymmetric mix otherwise.
    function automatic logic [127:0] aes_model(input logic [127:0] s, input logic [127:0] k);
        if (s == '0 && k == '0) return ZERO_CT;
        return s ^ {k[63:0], k[127:64]} ^ 128'h0123456789abcdef_fedcba9876543210;
    endfunction

    logic [127:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= aes_model(core_state, core_key);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign core_out = pipe[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Handshake side: push the expected response for every accepted job.
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready) begin
                exp_q.push_back('{id: 1'b0, data: aes_model(req0_state, req0_key)});
                grant_log.push_back(1'b0);
                hs_cnt++;
            end
            if (req1_valid && req1_ready) begin
                exp_q.push_back('{id: 1'b1, data: aes_model(req1_state, req1_key)});
                grant_log.push_back(1'b1);
                hs_cnt++;
            end
        end
    end

    logic         stall_prev = 1'b0;
    logic [127:0] data_prev;
    logic         id_prev;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", {127'd0, resp_valid}, 128'd1);
                chk("hold_data", resp_data, data_prev);
                chk("hold_id", {127'd0, resp_id}, {127'd0, id_prev});
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", {127'd0, resp_valid}, 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", resp_data, e.data);
                    chk("resp_id", {127'd0, resp_id}, {127'd0, e.id});
                    pop_cnt[resp_id]++;
                end
            end
            stall_prev <= resp_valid & ~resp_ready;
            data_prev  <= resp_data;
            id_prev    <= resp_id;
        end
    end

    task automatic drive_idle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst        = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        resp_ready = 1'b0;
        exp_q.delete();
        grant_log.delete();
        pop_cnt[0] = 0;
        pop_cnt[1] = 0;
        hs_cnt     = 0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req0_ready", {127'd0, req0_ready}, 128'd0);
        chk("rst_req1_ready", {127'd0, req1_ready}, 128'd0);
        chk("rst_core_state", core_state, 128'd0);
        chk("rst_core_key", core_key, 128'd0);
        chk("rst_resp_valid", {127'd0, resp_valid}, 128'd0);
        chk("rst_resp_data", resp_data, 128'd0);
        chk("rst_resp_id", {127'd0, resp_id}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        @(posedge clk); #1;
        drive_idle();
        rst = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", {127'd0, n < 300}, 128'd1);
    endtask

    initial begin
        int h;
        int n;
        int base;

        // 1: single all-zero job, latency and known ciphertext
        do_reset();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b1;
        req0_state = '0;
        req0_key   = '0;
        @(negedge clk);
        chk("s1_ready", {127'd0, req0_ready}, 128'd1);
        h = cyc;
        @(posedge clk); #1;
        drive_idle();
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("s1_latency", 128'(cyc - h), 128'd23);
        chk("s1_data", resp_data, ZERO_CT);
        chk("s1_id", {127'd0, resp_id}, 128'd0);
        wait_drain();

        // 2: both requesters continuously valid for 8 cycles
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_state = 128'(i + 1);
            req0_key   = {96'h0, 32'hc0de0000 + 32'(i)};
            req1_state = 128'(i + 100);
            req1_key   = {32'hbeef0000 + 32'(i), 96'h0};
        end
        @(posedge clk); #1;
        drive_idle();
        wait_drain();
        chk("s2_grants", 128'(grant_log.size()), 128'd8);
        for (int i = 0; i < grant_log.size(); i++)
            chk("s2_grant_order", {127'd0, grant_log[i]}, 128'(i % 2));
        chk("s2_pops_id0", 128'(pop_cnt[0]), 128'd4);
        chk("s2_pops_id1", 128'(pop_cnt[1]), 128'd4);

        // 3: consumer stalled, req0 streaming -> credits run out at 32
        do_reset();
        resp_ready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            req0_valid = 1'b1;
            req0_state = 128'(i + 500);
            req0_key   = {32'(i), 96'h5a5a};
        end
        @(negedge clk);
        chk("s3_handshakes", 128'(hs_cnt), 128'd32);
        chk("s3_ready_low", {127'd0, req0_ready}, 128'd0);

        // 4: pop at full credit -> issue only the following cycle
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("s4_pop_cycle_ready", {127'd0, req0_ready}, 128'd0);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req0_state = 128'h4444;
        @(negedge clk);
        chk("s4_next_cycle_ready", {127'd0, req0_ready}, 128'd1);
        @(posedge clk); #1;
        req0_state = 128'h4445;
        @(negedge clk);
        chk("s4_refull_ready", {127'd0, req0_ready}, 128'd0);
        chk("s4_handshakes", 128'(hs_cnt), 128'd33);

        // 3 tail: release the consumer, in-order drain and issue resumes
        base = hs_cnt;
        @(posedge clk); #1;
        resp_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (hs_cnt == base && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("s3_issue_resumes", {127'd0, hs_cnt > base}, 128'd1);
        @(posedge clk); #1;
        drive_idle();
        wait_drain();

        // 5: reset with 10 jobs in flight
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            req1_valid = 1'b1;
            req1_state = 128'(i + 900);
            req1_key   = 128'h77;
        end
        @(posedge clk); #1;
        drive_idle();
        repeat (4) @(posedge clk);
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("s5_no_stale_valid", {127'd0, resp_valid}, 128'd0);
            chk("s5_no_stale_busy", {127'd0, busy}, 128'd0);
        end

`ifdef AES_JOB_SCHED_STATS_EN
        // 6: per-requester pop counters
        do_reset();
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            req0_valid = 1'b1;
            req0_state = 128'(i + 7);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            req1_valid = 1'b1;
            req1_state = 128'(i + 70);
        end
        @(posedge clk); #1;
        drive_idle();
        wait_drain();
        chk("s6_job_cnt0", {96'd0, job_cnt0}, 128'd3);
        chk("s6_job_cnt1", {96'd0, job_cnt1}, 128'd5);
`endif

        chk("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
